sr_latch_ctrl: RTL and testbench
================================

# sr_latch_ctrl

Sequencer for a bank of N SR latches. It accepts set/reset commands over a valid/ready handshake and drives each latch's S/R inputs with registered pulses of programmable width. Each pulse is followed by a recovery gap, and the controller then reads back the latch Q to confirm that the command took effect. It sits between control logic and the SR latch bank. It guarantees that the forbidden input S=R=1 is never presented to any latch, and that at most one latch is driven at a time.

## Interface
- N, 4, number of latches in the bank (1..16)
- IDX_W, 2, width of cmd_idx; must satisfy 2**IDX_W >= N
- PULSE_W, 2, cycles S or R is held high per command (>= 1)
- GAP_W, 1, cycles S and R are both held low after the pulse, before readback (>= 0)
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller can accept a command
- cmd_set  in  1  1 = set latch (drive S), 0 = reset latch (drive R)
- cmd_idx  in  IDX_W  target latch index
- S  out  N  per-latch set inputs to the bank, registered
- R  out  N  per-latch reset inputs to the bank, registered
- Q  in  N  latch outputs, used for readback
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a command completes
- err  out  1  sticky error flag, cleared only by rst
- err_idx  out  IDX_W  index of the first failing command; frozen once err = 1

## Operation
- States: IDLE, PULSE, GAP, CHECK. One down-counter, wide enough for max(PULSE_W, GAP_W), shared by PULSE and GAP.
- IDLE
  - cmd_ready = 1.
  - When cmd_valid = 1, the command is accepted. The controller latches cmd_set and cmd_idx into tgt_set/tgt_idx.
  - cmd_idx < N: go to PULSE and load counter = PULSE_W.
  - cmd_idx >= N (out of range): go directly to CHECK with no pulse, and flag an error.
- PULSE
  - S[tgt_idx] = tgt_set and R[tgt_idx] = ~tgt_set. All other S/R bits are 0.
  - The counter decrements each cycle.
  - At count 1: go to GAP with counter = GAP_W if GAP_W > 0, otherwise go to CHECK.
- GAP
  - All S/R bits are 0; the counter decrements.
  - At count 1: go to CHECK.
- CHECK (one cycle)
  - All S/R bits are 0 and done = 1.
  - Mismatch condition: Q[tgt_idx] != tgt_set, or the index was out of range.
  - On mismatch with err = 0: set err = 1 and err_idx = tgt_idx.
  - On mismatch with err = 1: err and err_idx are unchanged.
  - Next state: IDLE.
- Invariants, checked every cycle:
  - (S & R) == 0.
  - At most one bit of (S | R) is high.
  - S and R are 0 outside PULSE.
- cmd_ready is 0 in PULSE, GAP and CHECK. Commands presented in those states are not consumed, and the requester holds them until accepted.
- A command to a latch already in the requested state is executed normally, with a full pulse and readback.

## Timing
- Reset values: state = IDLE, S = 0, R = 0, busy = 0, done = 0, err = 0, err_idx = 0, cmd_ready = 1.
- rst asserted mid-operation forces S/R to 0 immediately (asynchronously), abandons the command and produces no done. The latch bank keeps whatever state it reached.
- Accept edge is k. Timeline for an in-range command:
  - S or R high for cycles k+1 .. k+PULSE_W.
  - Gap for cycles k+PULSE_W+1 .. k+PULSE_W+GAP_W.
  - done high in cycle k+PULSE_W+GAP_W+1.
  - cmd_ready high again in cycle k+PULSE_W+GAP_W+2.
- Total occupancy per in-range command is PULSE_W + GAP_W + 1 cycles.
- Out-of-range command: done and err are high in cycle k+1; cmd_ready returns in cycle k+2.
- Q is sampled only in CHECK. The latch must settle within PULSE_W + GAP_W cycles.
- Back-to-back commands: the next accept occurs at the earliest on the edge that ends the CHECK cycle's successor (IDLE) cycle. There is no accept in CHECK.

## Test plan
- Reset then set latch 2 (PULSE_W=2, GAP_W=1, latch model attached) -> S = 4'b0100 for 2 cycles, 1 gap cycle, then done = 1 with Q[2] = 1 and err = 0.
- Set 2, then reset 2, then set 0 back-to-back with cmd_valid held -> each command is accepted only when cmd_ready = 1, done is pulsed three times, final Q = 4'b0001, and (S & R) == 0 on every cycle.
- Set latch 1 with a stuck-at-0 latch model on bit 1 -> err = 1 and err_idx = 1 at the done cycle; a later failing command on latch 3 leaves err_idx at 1.
- N=4, IDX_W=3, command cmd_idx = 5 -> no S/R activity, done and err rise one cycle after accept, err_idx = 5.
- Assert rst during the second PULSE cycle of a set -> S and R go to 0 in the same cycle; after reset release busy = 0, cmd_ready = 1, and no done pulse is produced.
- GAP_W = 0, PULSE_W = 1, reset latch 3 -> R = 4'b1000 for exactly 1 cycle and done in the following cycle.

Source files
------------

// File: rtl/sr_latch_ctrl.sv
// ============================================================================
// sr_latch_ctrl : pulse sequencer for a bank of SR latches with Q readback
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_ctrl #(
    parameter int N       = 4,
    parameter int IDX_W   = 2,
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_set,
    input  logic [IDX_W-1:0] cmd_idx,
    output logic [N-1:0]     S,
    output logic [N-1:0]     R,
    input  logic [N-1:0]     Q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [IDX_W-1:0] err_idx
);

    localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W:0]   N_VAL    = (IDX_W + 1)'(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tgt_set;
    logic [IDX_W-1:0] tgt_idx;
    logic             tgt_oor;
    logic             load_tgt;
    logic             in_range;
    logic             drive_set;
    logic [IDX_W-1:0] drive_idx;
    logic [N-1:0]     drive_lane;
    logic [N-1:0]     tgt_lane;
    logic [N-1:0]     s_nxt;
    logic [N-1:0]     r_nxt;
    logic             q_tgt;
    logic             mismatch;
    logic             fail_now;
    logic             err_q;
    logic [IDX_W-1:0] err_idx_q;

    assign in_range = ({1'b0, cmd_idx} < N_VAL);

    // Next-cycle drive target comes from the bus on the accept edge, else from the held command
    assign drive_set = load_tgt ? cmd_set : tgt_set;
    assign drive_idx = load_tgt ? cmd_idx : tgt_idx;

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            assign drive_lane[i] = (state_nxt == ST_PULSE) && (drive_idx == IDX_W'(i));
            assign tgt_lane[i]   = (tgt_idx == IDX_W'(i));
        end
    endgenerate

    assign s_nxt = drive_set ? drive_lane : '0;
    assign r_nxt = drive_set ? '0 : drive_lane;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_tgt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    load_tgt = 1'b1;
                    if (in_range) begin
                        state_nxt = ST_PULSE;
                        cnt_nxt   = PULSE_LD;
                    end else begin
                        state_nxt = ST_CHECK;
                    end
                end
            end
            ST_PULSE: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    if (GAP_W > 0) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = GAP_LD;
                    end else begin
                        state_nxt = ST_CHECK;
                    end
                end
            end
            ST_GAP: begin
                cnt_nxt = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            tgt_set <= 1'b0;
            tgt_idx <= '0;
            tgt_oor <= 1'b0;
            S       <= '0;
            R       <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            S     <= s_nxt;
            R     <= r_nxt;
            if (load_tgt) begin
                tgt_set <= cmd_set;
                tgt_idx <= cmd_idx;
                tgt_oor <= ~in_range;
            end
        end
    end

    // tgt_lane is all-zero for an out-of-range index, so no out-of-bounds select of Q
    assign q_tgt    = |(Q & tgt_lane);
    assign mismatch = tgt_oor | (q_tgt != tgt_set);
    assign fail_now = (state == ST_CHECK) && mismatch;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else if (fail_now && !err_q) begin
            err_q     <= 1'b1;
            err_idx_q <= tgt_idx;
        end
    end

    // The failure is already reported during the done cycle; the registers hold it afterwards
    assign err       = err_q | fail_now;
    assign err_idx   = err_q ? err_idx_q : (fail_now ? tgt_idx : '0);
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_CHECK);

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_ctrl.sv
// ============================================================================
// tb_sr_latch_ctrl : directed + randomized bench with latch-bank model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sr_latch_ctrl;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int GW = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: PULSE_W=2, GAP_W=1, 3-bit index so out-of-range commands exist
    logic       cmd_valid, cmd_ready, cmd_set, busy, done, err;
    logic [2:0] cmd_idx, err_idx;
    logic [3:0] S, R, Q;

    // DUT B: PULSE_W=1, GAP_W=0
    logic       b_valid, b_ready, b_set, b_busy, b_done, b_err;
    logic [1:0] b_idx, b_err_idx;
    logic [3:0] b_S, b_R, b_Q;

    sr_latch_ctrl #(.N(4), .IDX_W(3), .PULSE_W(PW), .GAP_W(GW)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_set(cmd_set), .cmd_idx(cmd_idx), .S(S), .R(R), .Q(Q),
        .busy(busy), .done(done), .err(err), .err_idx(err_idx)
    );

    sr_latch_ctrl #(.N(4), .IDX_W(2), .PULSE_W(1), .GAP_W(0)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_set(b_set), .cmd_idx(b_idx), .S(b_S), .R(b_R), .Q(b_Q),
        .busy(b_busy), .done(b_done), .err(b_err), .err_idx(b_err_idx)
    );

    // Latch banks: unaffected by controller reset; stuck bits read back as 0
    logic [3:0] bank   = '0;
    logic [3:0] b_bank = '0;
    logic [3:0] stuck  = '0;
    always @(posedge clk) bank   <= (bank | S) & ~R;
    always @(posedge clk) b_bank <= (b_bank | b_S) & ~b_R;
    assign Q   = bank & ~stuck;
    assign b_Q = b_bank;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state at command granularity
    logic [3:0] m_latch = '0;
    logic       m_err   = 1'b0;
    logic [2:0] m_idx   = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("inv_excl_a", 32'((S & R) == 4'b0), 32'd1);
            check("inv_one_a", 32'($countones(S | R) <= 1), 32'd1);
            check("inv_excl_b", 32'((b_S & b_R) == 4'b0), 32'd1);
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        b_valid   = 1'b0;
        m_err     = 1'b0;
        m_idx     = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Entered at a negedge in IDLE with the command already on the bus.
    // The next command (if nv) is presented right after acceptance and held.
    task automatic run_a(input bit set, input bit [2:0] idx,
                         input bit nv, input bit nset, input bit [2:0] nidx);
        bit         oor;
        bit         fail;
        int         len;
        logic [3:0] lane;
        logic [3:0] qv;
        oor = (idx >= 3'(N));
        len = oor ? 1 : PW + GW + 1;
        check("accept_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            lane = (!oor && c <= PW) ? 4'(1 << idx) : 4'b0;
            check("timeline", 32'({S, R, done, cmd_ready, busy}),
                  32'({set ? lane : 4'b0, set ? 4'b0 : lane, c == len, 1'b0, 1'b1}));
            if (c == 1) begin
                cmd_valid = nv;
                cmd_set   = nset;
                cmd_idx   = nidx;
            end
            if (c == len) begin
                if (!oor) m_latch[idx[1:0]] = set;
                qv   = m_latch & ~stuck;
                fail = oor || (qv[idx[1:0]] != set);
                if (fail && !m_err) begin
                    m_err = 1'b1;
                    m_idx = idx;
                end
                check("err_at_done", 32'({err, err_idx}), 32'({m_err, m_idx}));
            end
        end
        @(negedge clk);
        check("back_idle", 32'({S, R, done, cmd_ready, busy, err, err_idx}),
              32'({8'b0, 1'b0, 1'b1, 1'b0, m_err, m_idx}));
    endtask

    initial begin
        bit       cs, ns, nv;
        bit [2:0] ci, ni;
        cmd_set = 1'b0; cmd_idx = '0; b_set = 1'b0; b_idx = '0;
        do_reset();
        @(negedge clk);
        check("reset_a", 32'({S, R, busy, done, err, err_idx, cmd_ready}), 32'h1);
        check("reset_b", 32'({b_S, b_R, b_busy, b_done, b_err, b_err_idx, b_ready}), 32'h1);

        // Single set of latch 2
        cmd_valid = 1'b1; cmd_set = 1'b1; cmd_idx = 3'd2;
        run_a(1'b1, 3'd2, 1'b0, 1'b0, 3'd0);
        check("q_after_set2", 32'(Q), 32'h4);

        // Back-to-back with valid held: set 2 (already set), reset 2, set 0
        cmd_valid = 1'b1; cmd_set = 1'b1; cmd_idx = 3'd2;
        run_a(1'b1, 3'd2, 1'b1, 1'b0, 3'd2);
        run_a(1'b0, 3'd2, 1'b1, 1'b1, 3'd0);
        run_a(1'b1, 3'd0, 1'b0, 1'b0, 3'd0);
        check("q_after_b2b", 32'(Q), 32'h1);

        // Randomized commands, random stuck bits, random back-to-back spacing
        do_reset();
        @(negedge clk);
        stuck = 4'($urandom_range(0, 15)) & 4'b0110;
        cs = 1'($urandom_range(0, 1));
        ci = 3'($urandom_range(0, 5));
        cmd_valid = 1'b1; cmd_set = cs; cmd_idx = ci;
        for (int i = 0; i < 24; i++) begin
            ns = 1'($urandom_range(0, 1));
            ni = 3'($urandom_range(0, 5));
            nv = (i != 23) && ($urandom_range(0, 1) == 1);
            run_a(cs, ci, nv, ns, ni);
            if (!nv && i != 23) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                cmd_valid = 1'b1; cmd_set = ns; cmd_idx = ni;
            end
            cs = ns;
            ci = ni;
        end
        stuck = '0;

        // Out-of-range index
        do_reset();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_set = 1'b1; cmd_idx = 3'd5;
        run_a(1'b1, 3'd5, 1'b0, 1'b0, 3'd0);
        check("oor_err_idx", 32'({err, err_idx}), 32'({1'b1, 3'd5}));

        // Stuck-at-0 latches 1 and 3: first failure index is frozen
        do_reset();
        @(negedge clk);
        stuck = 4'b1010;
        cmd_valid = 1'b1; cmd_set = 1'b1; cmd_idx = 3'd1;
        run_a(1'b1, 3'd1, 1'b0, 1'b0, 3'd0);
        check("stuck_first", 32'({err, err_idx}), 32'({1'b1, 3'd1}));
        cmd_valid = 1'b1; cmd_set = 1'b1; cmd_idx = 3'd3;
        run_a(1'b1, 3'd3, 1'b0, 1'b0, 3'd0);
        check("stuck_frozen", 32'({err, err_idx}), 32'({1'b1, 3'd1}));
        stuck = '0;

        // Reset during the second pulse cycle of a set to latch 0
        cmd_valid = 1'b1; cmd_set = 1'b1; cmd_idx = 3'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_pulse1", 32'({S, R}), 32'h10);
        @(negedge clk);
        check("mid_pulse2", 32'({S, R}), 32'h10);
        #1 rst = 1'b1;
        #1 check("async_clear", 32'({S, R, busy, cmd_ready}), 32'h1);
        m_latch[0] = 1'b1;
        m_err = 1'b0;
        m_idx = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_idle", 32'({S, R, done, busy, cmd_ready, err}), 32'h2);
        end

        // DUT B: reset latch 3 with PULSE_W=1, GAP_W=0
        b_valid = 1'b1; b_set = 1'b0; b_idx = 2'd3;
        @(posedge clk);
        @(negedge clk);
        b_valid = 1'b0;
        check("b_pulse", 32'({b_S, b_R, b_done, b_ready}), 32'({4'b0, 4'b1000, 1'b0, 1'b0}));
        @(negedge clk);
        check("b_done", 32'({b_S, b_R, b_done, b_ready, b_err}), 32'({8'b0, 1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        check("b_idle", 32'({b_S, b_R, b_done, b_ready, b_busy}), 32'({8'b0, 1'b0, 1'b1, 1'b0}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
